// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream output among
// N_SOURCES inputs; a grant is held from a packet's first beat through t_last.
module stream_packet_arbiter #(
  parameter  int N_SOURCES  = 4,
  parameter  int DATA_WIDTH = 64,
  parameter  int ID_WIDTH   = 1,
  parameter  int DEST_WIDTH = 1,
  parameter  int USER_WIDTH = 1,
  localparam int SEL_WIDTH  = $clog2(N_SOURCES),
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [N_SOURCES-1:0]             s_t_valid,
  output logic [N_SOURCES-1:0]             s_t_ready,
  input  logic [N_SOURCES*DATA_WIDTH-1:0]  s_t_data,
  input  logic [N_SOURCES*STRB_WIDTH-1:0]  s_t_strb,
  input  logic [N_SOURCES*STRB_WIDTH-1:0]  s_t_keep,
  input  logic [N_SOURCES-1:0]             s_t_last,
  input  logic [N_SOURCES*ID_WIDTH-1:0]    s_t_id,
  input  logic [N_SOURCES*DEST_WIDTH-1:0]  s_t_dest,
  input  logic [N_SOURCES*USER_WIDTH-1:0]  s_t_user,
  output logic                             m_t_valid,
  input  logic                             m_t_ready,
  output logic [DATA_WIDTH-1:0]            m_t_data,
  output logic [STRB_WIDTH-1:0]            m_t_strb,
  output logic [STRB_WIDTH-1:0]            m_t_keep,
  output logic                             m_t_last,
  output logic [ID_WIDTH-1:0]              m_t_id,
  output logic [DEST_WIDTH-1:0]            m_t_dest,
  output logic [USER_WIDTH-1:0]            m_t_user,
  output logic [SEL_WIDTH-1:0]             grant_sel,
  output logic                             busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] winner;
  logic                 any_valid;
  logic [SEL_WIDTH:0]   scan_idx;

  assign busy = (state == BUSY);

  // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap so non-power-of-two
  // source counts never alias onto a nonexistent index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    winner    = '0;
    any_valid = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < N_SOURCES; k++) begin
      scan_idx = {1'b0, rr_ptr} + (SEL_WIDTH+1)'(k);
      if (scan_idx >= (SEL_WIDTH+1)'(N_SOURCES))
        scan_idx = scan_idx - (SEL_WIDTH+1)'(N_SOURCES);
      if (!any_valid && s_t_valid[scan_idx[SEL_WIDTH-1:0]]) begin
        any_valid = 1'b1;
        winner    = scan_idx[SEL_WIDTH-1:0];
      end
    end
  end

  // Unbuffered datapath: the granted slice passes straight through.
  always_comb begin
    m_t_valid = 1'b0;
    s_t_ready = '0;
    m_t_data  = '0;
    m_t_strb  = '0;
    m_t_keep  = '0;
    m_t_last  = 1'b0;
    m_t_id    = '0;
    m_t_dest  = '0;
    m_t_user  = '0;
    for (int i = 0; i < N_SOURCES; i++) begin
      if (grant_sel == SEL_WIDTH'(i)) begin
        m_t_valid    = busy & s_t_valid[i];
        s_t_ready[i] = busy & m_t_ready;
        m_t_data     = s_t_data[i*DATA_WIDTH +: DATA_WIDTH];
        m_t_strb     = s_t_strb[i*STRB_WIDTH +: STRB_WIDTH];
        m_t_keep     = s_t_keep[i*STRB_WIDTH +: STRB_WIDTH];
        m_t_last     = s_t_last[i];
        m_t_id       = s_t_id[i*ID_WIDTH +: ID_WIDTH];
        m_t_dest     = s_t_dest[i*DEST_WIDTH +: DEST_WIDTH];
        m_t_user     = s_t_user[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_sel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_sel <= winner;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Only a completed t_last beat releases the grant.
          if (m_t_valid && m_t_ready && m_t_last) begin
            state  <= IDLE;
            rr_ptr <= (grant_sel == SEL_WIDTH'(N_SOURCES-1)) ? '0
                                                             : grant_sel + SEL_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed bench for stream_packet_arbiter: each task drives source packets
// and compares the output handshake view against hand-computed tables.
module tb_stream_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    s_t_valid = '0;
  logic [N-1:0]    s_t_ready;
  logic [N*DW-1:0] s_t_data = '0;
  logic [N*SW-1:0] s_t_strb = '0;
  logic [N*SW-1:0] s_t_keep = '0;
  logic [N-1:0]    s_t_last = '0;
  logic [N-1:0]    s_t_id = '0;
  logic [N-1:0]    s_t_dest = '0;
  logic [N-1:0]    s_t_user = '0;
  logic            m_t_valid;
  logic            m_t_ready = 1'b0;
  logic [DW-1:0]   m_t_data;
  logic [SW-1:0]   m_t_strb;
  logic [SW-1:0]   m_t_keep;
  logic            m_t_last;
  logic [0:0]      m_t_id;
  logic [0:0]      m_t_dest;
  logic [0:0]      m_t_user;
  logic [1:0]      grant_sel;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;
  int npkts [N] = '{0, 0, 0, 0};
  int len   [N] = '{1, 1, 1, 1};
  int beat  [N] = '{0, 0, 0, 0};

  stream_packet_arbiter dut (
    .clk(clk), .rstn(rstn),
    .s_t_valid(s_t_valid), .s_t_ready(s_t_ready), .s_t_data(s_t_data),
    .s_t_strb(s_t_strb), .s_t_keep(s_t_keep), .s_t_last(s_t_last),
    .s_t_id(s_t_id), .s_t_dest(s_t_dest), .s_t_user(s_t_user),
    .m_t_valid(m_t_valid), .m_t_ready(m_t_ready), .m_t_data(m_t_data),
    .m_t_strb(m_t_strb), .m_t_keep(m_t_keep), .m_t_last(m_t_last),
    .m_t_id(m_t_id), .m_t_dest(m_t_dest), .m_t_user(m_t_user),
    .grant_sel(grant_sel), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [63:0] word(input int src, input int bt);
    return {8'hD0, 8'(src), 32'h0, 16'(bt)};
  endfunction

  function automatic logic [18:0] side(input logic [1:0] s);
    return {8'(1 << s), 8'hF0 | {6'b0, s}, s[0], ~s[0], s[1]};
  endfunction

  // {busy, grant_sel (only while busy), m_t_valid, m_t_last (only while valid), s_t_ready}
  function automatic logic [8:0] obs();
    return {busy, busy ? grant_sel : 2'b00, m_t_valid, m_t_valid & m_t_last, s_t_ready};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [1:0] s;
      s = 2'(i);
      s_t_valid[i]         = npkts[i] > 0;
      s_t_last[i]          = (beat[i] == len[i] - 1);
      s_t_data[i*DW +: DW] = word(i, beat[i]);
      s_t_strb[i*SW +: SW] = 8'(1 << s);
      s_t_keep[i*SW +: SW] = 8'hF0 | {6'b0, s};
      s_t_id[i]            = s[0];
      s_t_dest[i]          = ~s[0];
      s_t_user[i]          = s[1];
    end
  endtask

  // Advance one clock: source beat counters move on the handshakes seen before
  // the edge, new inputs go out at the falling edge, outputs settle 1 ns later.
  task automatic cycle();
    logic [N-1:0] fire;
    fire = s_t_valid & s_t_ready;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i]  = 0;
          npkts[i] = npkts[i] - 1;
        end else begin
          beat[i] = beat[i] + 1;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      npkts[i] = 1; len[i] = 1; beat[i] = 0;
    end
    m_t_ready = 1'b1;
    drive();
    #2;
    for (int k = 0; k < 2; k++) begin
      if (obs() !== 9'b0) begin
        miscompares++;
        $display("FAIL reset c%0d obs=%b exp=%b", k, obs(), 9'b0);
      end
      vectors++;
      if (k == 0) cycle();
    end
    for (int i = 0; i < N; i++) npkts[i] = 0;
    rstn = 1'b1;
    drive();
    #1;
  endtask

  task automatic test_round_robin();
    logic [8:0] exp [16];
    int eb = 0;
    exp = '{9'b0_00_00_0000, 9'b1_00_10_0001, 9'b1_00_11_0001, 9'b0_00_00_0000,
            9'b1_01_10_0010, 9'b1_01_11_0010, 9'b0_00_00_0000,
            9'b1_10_10_0100, 9'b1_10_11_0100, 9'b0_00_00_0000,
            9'b1_11_10_1000, 9'b1_11_11_1000, 9'b0_00_00_0000,
            9'b1_00_10_0001, 9'b1_00_11_0001, 9'b0_00_00_0000};
    npkts = '{2, 1, 1, 1};
    len   = '{2, 2, 2, 2};
    m_t_ready = 1'b1;
    drive();
    #1;
    for (int k = 0; k < 16; k++) begin
      if (obs() !== exp[k]) begin
        miscompares++;
        $display("FAIL round_robin c%0d obs=%b exp=%b", k, obs(), exp[k]);
      end
      vectors++;
      if (exp[k][5]) begin
        if (m_t_data !== word(exp[k][7:6], eb)) begin
          miscompares++;
          $display("FAIL round_robin_data c%0d data=%h exp=%h", k, m_t_data, word(exp[k][7:6], eb));
        end
        vectors++;
        if ({m_t_strb, m_t_keep, m_t_id, m_t_dest, m_t_user} !== side(exp[k][7:6])) begin
          miscompares++;
          $display("FAIL round_robin_side c%0d got=%h exp=%h", k,
                   {m_t_strb, m_t_keep, m_t_id, m_t_dest, m_t_user}, side(exp[k][7:6]));
        end
        vectors++;
        if (exp[k][3:0] != 4'b0) eb = exp[k][4] ? 0 : eb + 1;
      end
      if (k < 15) cycle();
    end
  endtask

  task automatic test_single_source();
    logic [8:0] exp [5];
    int eb = 0;
    exp = '{9'b0_00_00_0000, 9'b1_10_10_0100, 9'b1_10_10_0100,
            9'b1_10_11_0100, 9'b0_00_00_0000};
    npkts[2] = 1; len[2] = 3;
    drive();
    #1;
    for (int k = 0; k < 5; k++) begin
      if (obs() !== exp[k]) begin
        miscompares++;
        $display("FAIL single_source c%0d obs=%b exp=%b", k, obs(), exp[k]);
      end
      vectors++;
      if (exp[k][5]) begin
        if (m_t_data !== word(2, eb)) begin
          miscompares++;
          $display("FAIL single_source_data c%0d data=%h exp=%h", k, m_t_data, word(2, eb));
        end
        vectors++;
        eb = eb + 1;
      end
      if (k < 4) cycle();
    end
  endtask

  task automatic test_wrap_skip();
    logic [8:0] exp [7];
    exp = '{9'b0_00_00_0000, 9'b1_11_11_1000, 9'b0_00_00_0000, 9'b1_01_11_0010,
            9'b0_00_00_0000, 9'b1_01_11_0010, 9'b0_00_00_0000};
    npkts[1] = 2; len[1] = 1;
    npkts[3] = 1; len[3] = 1;
    drive();
    #1;
    for (int k = 0; k < 7; k++) begin
      if (obs() !== exp[k]) begin
        miscompares++;
        $display("FAIL wrap_skip c%0d obs=%b exp=%b", k, obs(), exp[k]);
      end
      vectors++;
      if (k < 6) cycle();
    end
  endtask

  task automatic test_late_requester();
    logic [8:0] exp [6];
    exp = '{9'b0_00_00_0000, 9'b1_10_10_0100, 9'b1_10_11_0100,
            9'b0_00_00_0000, 9'b1_00_11_0001, 9'b0_00_00_0000};
    npkts[2] = 1; len[2] = 2;
    drive();
    #1;
    npkts[0] = 1; len[0] = 1;
    drive();
    #1;
    for (int k = 0; k < 6; k++) begin
      if (obs() !== exp[k]) begin
        miscompares++;
        $display("FAIL late_requester c%0d obs=%b exp=%b", k, obs(), exp[k]);
      end
      vectors++;
      if (k < 5) cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp [9];
    logic       rdy [9];
    int eb = 0;
    exp = '{9'b0_00_00_0000, 9'b1_01_10_0010, 9'b1_01_10_0000, 9'b1_01_10_0000,
            9'b1_01_10_0010, 9'b1_01_11_0010, 9'b0_00_00_0000, 9'b1_00_11_0001,
            9'b0_00_00_0000};
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    npkts[1] = 1; len[1] = 3;
    npkts[0] = 1; len[0] = 1;
    drive();
    for (int k = 0; k < 9; k++) begin
      m_t_ready = rdy[k];
      #1;
      if (obs() !== exp[k]) begin
        miscompares++;
        $display("FAIL backpressure c%0d obs=%b exp=%b", k, obs(), exp[k]);
      end
      vectors++;
      if (exp[k][5]) begin
        if (m_t_data !== word(exp[k][7:6], eb)) begin
          miscompares++;
          $display("FAIL backpressure_data c%0d data=%h exp=%h", k, m_t_data, word(exp[k][7:6], eb));
        end
        vectors++;
        if (exp[k][3:0] != 4'b0) eb = exp[k][4] ? 0 : eb + 1;
      end
      if (k < 8) cycle();
    end
    m_t_ready = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    logic [8:0] exp [5];
    exp = '{9'b0_00_00_0000, 9'b1_00_11_0001, 9'b0_00_00_0000,
            9'b1_10_11_0100, 9'b0_00_00_0000};
    npkts[3] = 1; len[3] = 4;
    m_t_ready = 1'b1;
    drive();
    #1;
    cycle();
    cycle();
    if (obs() !== 9'b1_11_10_1000 || m_t_data !== word(3, 1)) begin
      miscompares++;
      $display("FAIL mid_packet_beat2 obs=%b data=%h exp=%b/%h", obs(), m_t_data,
               9'b1_11_10_1000, word(3, 1));
    end
    vectors++;
    rstn = 1'b0;
    #1;
    if (obs() !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_immediate obs=%b exp=%b", obs(), 9'b0);
    end
    vectors++;
    npkts[3] = 0; beat[3] = 0;
    npkts[0] = 1; len[0] = 1;
    npkts[2] = 1; len[2] = 1;
    drive();
    cycle();
    if (obs() !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_held obs=%b exp=%b", obs(), 9'b0);
    end
    vectors++;
    rstn = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (obs() !== exp[k]) begin
        miscompares++;
        $display("FAIL after_reset c%0d obs=%b exp=%b", k, obs(), exp[k]);
      end
      vectors++;
      if (k < 4) cycle();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_source();
    test_wrap_skip();
    test_late_requester();
    test_backpressure();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
